// File: rtl/load_refill_responder_pkg.sv
// Shared types and constants for the DCache-to-load-queue refill responder.
// Holds the per-entry record, the entry lifecycle and the redirect age compare.
package load_refill_responder_pkg;

  localparam int LQ_WIDTH    = 5;
  localparam int PADDR_SIZE  = 32;
  localparam int LINE_OFF    = 6;
  localparam int DBYTE_WIDTH = 3;
  localparam int DATA_BITS   = 8 << DBYTE_WIDTH;
  localparam int LINE_BITS   = PADDR_SIZE - LINE_OFF;
  localparam int BEAT_BITS   = LINE_OFF - DBYTE_WIDTH;
  localparam int MISS_PORTS  = 2;
  localparam int REFILL_SIZE = 2;

  typedef logic [LQ_WIDTH:0] lq_idx_t;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } entry_state_e;

  typedef struct packed {
    lq_idx_t                lq_idx;
    logic [LINE_BITS-1:0]   line;
    logic [BEAT_BITS-1:0]   beat;
    logic [DATA_BITS-1:0]   data;
  } load_refill_entry_t;

  // True when idx is the same age as, or younger than, the flush point in
  // circular load-queue order; the dir bit flips on every wrap.
  function automatic logic is_squashed(input lq_idx_t idx, input lq_idx_t flush);
    if (idx[LQ_WIDTH] == flush[LQ_WIDTH])
      return idx[LQ_WIDTH-1:0] >= flush[LQ_WIDTH-1:0];
    else
      return idx[LQ_WIDTH-1:0] < flush[LQ_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/load_refill_responder_pick.sv
// Two-ended priority picker: lowest and highest set request bit, plus a flag
// that says the two ends name different entries.
module load_refill_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         any,
  output logic         distinct
);

  // NOTE: every output gets a default before the loops so no latch is inferred.
  always_comb begin
    lo  = '0;
    hi  = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) lo = W'(i);
    for (int i = 0; i < N; i++)
      if (req[i]) hi = W'(i);
    distinct = any && (lo != hi);
  end

endmodule

// File: rtl/load_refill_responder.sv
// Records load misses, matches returning refill beats against them and sends
// up to two registered refill responses per cycle to the load queue.
module load_refill_responder
  import load_refill_responder_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [MISS_PORTS-1:0]              miss_en,
  input  logic [MISS_PORTS*(LQ_WIDTH+1)-1:0] miss_lqIdx,
  input  logic [MISS_PORTS*PADDR_SIZE-1:0]   miss_paddr,
  output logic                               miss_ready,
  input  logic                               refill_en,
  input  logic [LINE_BITS-1:0]               refill_line,
  input  logic [BEAT_BITS-1:0]               refill_beat,
  input  logic [DATA_BITS-1:0]               refill_data,
  input  logic                               flush_en,
  input  logic [LQ_WIDTH:0]                  flush_lqIdx,
  output logic [REFILL_SIZE-1:0]             lq_en,
  output logic [REFILL_SIZE*LQ_WIDTH-1:0]    lqIdx_o,
  output logic [REFILL_SIZE*DATA_BITS-1:0]   lqData
);

  localparam int IW = $clog2(ENTRIES);

  entry_state_e       state_q [ENTRIES];
  entry_state_e       state_d [ENTRIES];
  load_refill_entry_t entry_q [ENTRIES];
  load_refill_entry_t entry_d [ENTRIES];

  logic [ENTRIES-1:0] free_vec, ready_vec;
  logic [IW-1:0]      free_lo, free_hi, rdy_lo, rdy_hi;
  logic               free_any, free_distinct, rdy_any, rdy_distinct;
  logic [IW:0]        free_cnt;

  lq_idx_t              miss_idx  [MISS_PORTS];
  logic [LINE_BITS-1:0] miss_line [MISS_PORTS];
  logic [BEAT_BITS-1:0] miss_beat [MISS_PORTS];
  logic                 alloc_en  [MISS_PORTS];
  logic [IW-1:0]        alloc_slot[MISS_PORTS];
  logic [REFILL_SIZE-1:0] lq_en_d;

  logic unused_paddr_bits;
  assign unused_paddr_bits = ^{miss_paddr[DBYTE_WIDTH-1:0],
                               miss_paddr[PADDR_SIZE+DBYTE_WIDTH-1:PADDR_SIZE]};

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      free_vec[i]  = (state_q[i] == FREE);
      ready_vec[i] = (state_q[i] == READY);
      if (free_vec[i]) free_cnt = free_cnt + (IW+1)'(1);
    end
  end

  assign miss_ready = (free_cnt >= (IW+1)'(MISS_PORTS));

  load_refill_pick #(.N(ENTRIES), .W(IW)) u_free_pick (
    .req(free_vec), .lo(free_lo), .hi(free_hi), .any(free_any), .distinct(free_distinct)
  );

  load_refill_pick #(.N(ENTRIES), .W(IW)) u_ready_pick (
    .req(ready_vec), .lo(rdy_lo), .hi(rdy_hi), .any(rdy_any), .distinct(rdy_distinct)
  );

  always_comb begin
    for (int p = 0; p < MISS_PORTS; p++) begin
      miss_idx[p]  = miss_lqIdx[p*(LQ_WIDTH+1) +: LQ_WIDTH+1];
      miss_line[p] = miss_paddr[p*PADDR_SIZE+LINE_OFF +: LINE_BITS];
      miss_beat[p] = miss_paddr[p*PADDR_SIZE+DBYTE_WIDTH +: BEAT_BITS];
      alloc_en[p]  = miss_en[p] && miss_ready;
    end
    alloc_slot[0] = free_lo;
    alloc_slot[1] = free_hi;
  end

  // Flush is applied last so it overrides selection, capture and allocation.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      state_d[i] = state_q[i];
      entry_d[i] = entry_q[i];
      if (state_q[i] == READY &&
          ((rdy_any && rdy_lo == IW'(i)) || (rdy_distinct && rdy_hi == IW'(i))))
        state_d[i] = FREE;
      if (state_q[i] == WAIT && refill_en &&
          entry_q[i].line == refill_line && entry_q[i].beat == refill_beat) begin
        state_d[i]      = READY;
        entry_d[i].data = refill_data;
      end
      for (int p = 0; p < MISS_PORTS; p++) begin
        if (alloc_en[p] && alloc_slot[p] == IW'(i)) begin
          entry_d[i].lq_idx = miss_idx[p];
          entry_d[i].line   = miss_line[p];
          entry_d[i].beat   = miss_beat[p];
          entry_d[i].data   = refill_data;
          state_d[i] = (refill_en && miss_line[p] == refill_line &&
                        miss_beat[p] == refill_beat) ? READY : WAIT;
        end
      end
      if (flush_en && state_d[i] != FREE && is_squashed(entry_d[i].lq_idx, flush_lqIdx))
        state_d[i] = FREE;
    end
    lq_en_d[0] = rdy_any &&
                 !(flush_en && is_squashed(entry_q[rdy_lo].lq_idx, flush_lqIdx));
    lq_en_d[1] = rdy_distinct &&
                 !(flush_en && is_squashed(entry_q[rdy_hi].lq_idx, flush_lqIdx));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) state_q[i] <= FREE;
      lq_en   <= '0;
      lqIdx_o <= '0;
      lqData  <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) state_q[i] <= state_d[i];
      lq_en <= lq_en_d;
      if (lq_en_d[0]) begin
        lqIdx_o[0 +: LQ_WIDTH]  <= entry_q[rdy_lo].lq_idx[LQ_WIDTH-1:0];
        lqData[0 +: DATA_BITS]  <= entry_q[rdy_lo].data;
      end
      if (lq_en_d[1]) begin
        lqIdx_o[LQ_WIDTH +: LQ_WIDTH]   <= entry_q[rdy_hi].lq_idx[LQ_WIDTH-1:0];
        lqData[DATA_BITS +: DATA_BITS]  <= entry_q[rdy_hi].data;
      end
    end
  end

  // NOTE: the payload array is not reset; its contents are only read while
  // the matching state is WAIT or READY, which reset clears.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) entry_q[i] <= entry_d[i];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < MISS_PORTS; p++) begin
        if (miss_en[p])
          assert (miss_ready)
            else $warning("miss_en on port %0d dropped: fewer than two free entries", p);
        if (alloc_en[p])
          for (int i = 0; i < ENTRIES; i++)
            if (state_q[i] != FREE)
              assert (entry_q[i].lq_idx != miss_idx[p])
                else $error("duplicate live lqIdx %0h on port %0d", miss_idx[p], p);
      end
      if (alloc_en[0] && alloc_en[1])
        assert (miss_idx[0] != miss_idx[1])
          else $error("both miss ports carry lqIdx %0h", miss_idx[0]);
    end
  end

endmodule

// File: tb/tb_load_refill_responder.sv
// Directed self-checking bench for load_refill_responder: allocation, refill
// match, dual-ended response select, bypass and redirect squash.
module tb_load_refill_responder;
  import load_refill_responder_pkg::*;

  logic                               clk = 1'b0;
  logic                               rst;
  logic [MISS_PORTS-1:0]              miss_en;
  logic [MISS_PORTS*(LQ_WIDTH+1)-1:0] miss_lqIdx;
  logic [MISS_PORTS*PADDR_SIZE-1:0]   miss_paddr;
  logic                               miss_ready;
  logic                               refill_en;
  logic [LINE_BITS-1:0]               refill_line;
  logic [BEAT_BITS-1:0]               refill_beat;
  logic [DATA_BITS-1:0]               refill_data;
  logic                               flush_en;
  logic [LQ_WIDTH:0]                  flush_lqIdx;
  logic [REFILL_SIZE-1:0]             lq_en;
  logic [REFILL_SIZE*LQ_WIDTH-1:0]    lqIdx_o;
  logic [REFILL_SIZE*DATA_BITS-1:0]   lqData;

  int checks   = 0;
  int failures = 0;

  load_refill_responder dut (
    .clk(clk), .rst(rst),
    .miss_en(miss_en), .miss_lqIdx(miss_lqIdx), .miss_paddr(miss_paddr),
    .miss_ready(miss_ready),
    .refill_en(refill_en), .refill_line(refill_line), .refill_beat(refill_beat),
    .refill_data(refill_data),
    .flush_en(flush_en), .flush_lqIdx(flush_lqIdx),
    .lq_en(lq_en), .lqIdx_o(lqIdx_o), .lqData(lqData)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    miss_en     = '0;
    miss_lqIdx  = '0;
    miss_paddr  = '0;
    refill_en   = 1'b0;
    refill_line = '0;
    refill_beat = '0;
    refill_data = '0;
    flush_en    = 1'b0;
    flush_lqIdx = '0;
  endtask

  function automatic logic [31:0] pa(input logic [25:0] line, input logic [2:0] beat);
    return {line, beat, 3'b000};
  endfunction

  task automatic set_miss(input int p, input logic [5:0] idx, input logic [31:0] addr);
    miss_en[p]            = 1'b1;
    miss_lqIdx[p*6 +: 6]  = idx;
    miss_paddr[p*32 +: 32] = addr;
  endtask

  task automatic set_refill(input logic [25:0] line, input logic [2:0] beat,
                            input logic [63:0] data);
    refill_en   = 1'b1;
    refill_line = line;
    refill_beat = beat;
    refill_data = data;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    tick(); tick();
    check("reset_lq_en", 64'(lq_en), 64'h0);
    check("reset_lqIdx", 64'(lqIdx_o), 64'h0);
    check("reset_lqData_lo", lqData[63:0], 64'h0);
    check("reset_miss_ready", 64'(miss_ready), 64'h1);
    rst = 1'b1;
    tick();

    // Single miss, later refill, response two cycles after the refill.
    clear_inputs(); set_miss(0, 6'd3, 32'h8000_0048); tick();
    clear_inputs(); tick();
    set_refill(26'h200_0001, 3'd1, 64'hDEAD); tick();
    clear_inputs();
    check("t1_n1_lq_en", 64'(lq_en), 64'h0);
    tick();
    check("t1_lq_en", 64'(lq_en), 64'h1);
    check("t1_lqIdx0", 64'(lqIdx_o[4:0]), 64'd3);
    check("t1_lqData0", lqData[63:0], 64'hDEAD);
    tick();
    check("t1_after_lq_en", 64'(lq_en), 64'h0);
    check("t1_hold_lqData0", lqData[63:0], 64'hDEAD);
    check("t1_miss_ready", 64'(miss_ready), 64'h1);

    // Three misses on one beat: lowest/highest entries first, middle next.
    clear_inputs();
    set_miss(0, 6'd1, pa(26'h012_3456, 3'd5));
    set_miss(1, 6'd5, pa(26'h012_3456, 3'd5)); tick();
    clear_inputs(); set_miss(0, 6'd2, pa(26'h012_3456, 3'd5)); tick();
    clear_inputs(); set_refill(26'h012_3456, 3'd5, 64'h1111_2222_3333_4444); tick();
    clear_inputs(); tick();
    check("t2_lq_en", 64'(lq_en), 64'h3);
    check("t2_lqIdx0", 64'(lqIdx_o[4:0]), 64'd1);
    check("t2_lqIdx1", 64'(lqIdx_o[9:5]), 64'd5);
    check("t2_lqData1", lqData[127:64], 64'h1111_2222_3333_4444);
    tick();
    check("t2_second_lq_en", 64'(lq_en), 64'h1);
    check("t2_second_lqIdx0", 64'(lqIdx_o[4:0]), 64'd2);
    check("t2_hold_lqIdx1", 64'(lqIdx_o[9:5]), 64'd5);
    tick();
    check("t2_drained_lq_en", 64'(lq_en), 64'h0);

    // Fill all entries; line of each load is 0x100 + lqIdx.
    for (int k = 0; k < 4; k++) begin
      clear_inputs();
      set_miss(0, 6'(10 + 2*k), pa(26'(32'h100 + 10 + 2*k), 3'd0));
      set_miss(1, 6'(11 + 2*k), pa(26'(32'h100 + 11 + 2*k), 3'd0));
      tick();
      if (k == 2) check("t3_ready_two_free", 64'(miss_ready), 64'h1);
    end
    clear_inputs();
    check("t3_full_ready", 64'(miss_ready), 64'h0);
    set_miss(0, 6'd20, pa(26'h120, 3'd0));
    set_miss(1, 6'd21, pa(26'h121, 3'd0)); tick();
    clear_inputs();
    check("t3_ignored_ready", 64'(miss_ready), 64'h0);
    set_refill(26'h10A, 3'd0, 64'hA0A0); tick();
    clear_inputs(); tick();
    check("t3_free1_lq_en", 64'(lq_en), 64'h1);
    check("t3_free1_lqIdx0", 64'(lqIdx_o[4:0]), 64'd10);
    check("t3_one_free_ready", 64'(miss_ready), 64'h0);
    set_refill(26'h10B, 3'd0, 64'hB0B0); tick();
    clear_inputs(); tick();
    check("t3_free2_lqIdx0", 64'(lqIdx_o[4:0]), 64'd11);
    check("t3_two_free_ready", 64'(miss_ready), 64'h1);
    for (int k = 12; k < 18; k++) begin
      clear_inputs(); set_refill(26'(32'h100 + k), 3'd0, 64'(k)); tick();
    end
    clear_inputs(); tick(); tick(); tick(); tick();
    check("t3_drain_lq_en", 64'(lq_en), 64'h0);
    set_refill(26'h120, 3'd0, 64'hDEAD_0120); tick();
    clear_inputs(); tick();
    check("t3_ignored_no_resp", 64'(lq_en), 64'h0);

    // Bypass: miss and matching refill in the same cycle.
    clear_inputs();
    set_miss(0, 6'd4, pa(26'h0AB_CDE, 3'd2));
    set_refill(26'h0AB_CDE, 3'd2, 64'hBEEF); tick();
    clear_inputs();
    check("t4_n1_lq_en", 64'(lq_en), 64'h0);
    tick();
    check("t4_lq_en", 64'(lq_en), 64'h1);
    check("t4_lqIdx0", 64'(lqIdx_o[4:0]), 64'd4);
    check("t4_lqData0", lqData[63:0], 64'hBEEF);

    // Flush at dir0:8 kills dir0:9 and dir1:1 but keeps dir0:6.
    clear_inputs();
    set_miss(0, 6'h06, pa(26'h306, 3'd0));
    set_miss(1, 6'h09, pa(26'h309, 3'd0)); tick();
    clear_inputs(); set_miss(0, 6'h21, pa(26'h321, 3'd0)); tick();
    clear_inputs(); flush_en = 1'b1; flush_lqIdx = 6'h08; tick();
    clear_inputs(); set_refill(26'h309, 3'd0, 64'h9999); tick();
    clear_inputs(); tick();
    check("t5_killed9_no_resp", 64'(lq_en), 64'h0);
    set_refill(26'h321, 3'd0, 64'h2121); tick();
    clear_inputs(); tick();
    check("t5_killed_dir1_no_resp", 64'(lq_en), 64'h0);
    set_refill(26'h306, 3'd0, 64'h6666); tick();
    clear_inputs(); tick();
    check("t5_survivor_lq_en", 64'(lq_en), 64'h1);
    check("t5_survivor_lqIdx0", 64'(lqIdx_o[4:0]), 64'd6);
    check("t5_survivor_data", lqData[63:0], 64'h6666);

    // Flush in the selection cycle suppresses the response for lqIdx 7.
    clear_inputs(); set_miss(0, 6'h07, pa(26'h407, 3'd0)); tick();
    clear_inputs(); set_refill(26'h407, 3'd0, 64'h7777); tick();
    clear_inputs(); flush_en = 1'b1; flush_lqIdx = 6'h07; tick();
    clear_inputs();
    check("t6_flushed_lq_en", 64'(lq_en), 64'h0);
    check("t6_hold_lqData0", lqData[63:0], 64'h6666);
    tick();
    check("t6_flushed_later", 64'(lq_en), 64'h0);
    set_refill(26'h407, 3'd0, 64'h7778); tick();
    clear_inputs(); tick();
    check("t6_entry_freed", 64'(lq_en), 64'h0);
    check("t6_miss_ready", 64'(miss_ready), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
